// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Request/response bundle for alu_pipe. The request side carries
//            in_valid/in_ready, a, b and op. The response side carries
//            out_valid/out_ready, result, flags and err.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             err;

  // Requester / result consumer side
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, err
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage pipelined ALU with a valid/ready handshake on both the
//            request side and the result side. The carry used by ADC and SBC
//            lives in an internal register. That register is updated as each
//            op is accepted, so back-to-back carry chains see no hazard.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_pipe_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] C_OP_ADD  = 4'd0;
  localparam logic [3:0] C_OP_SUB  = 4'd1;
  localparam logic [3:0] C_OP_NOT  = 4'd2;
  localparam logic [3:0] C_OP_NAND = 4'd3;
  localparam logic [3:0] C_OP_NOR  = 4'd4;
  localparam logic [3:0] C_OP_AND  = 4'd5;
  localparam logic [3:0] C_OP_OR   = 4'd6;
  localparam logic [3:0] C_OP_XOR  = 4'd7;
  localparam logic [3:0] C_OP_SHL  = 4'd8;
  localparam logic [3:0] C_OP_SHR  = 4'd9;
  localparam logic [3:0] C_OP_SAR  = 4'd10;
  localparam logic [3:0] C_OP_ADC  = 4'd11;
  localparam logic [3:0] C_OP_SBC  = 4'd12;
  localparam logic [3:0] C_OP_PASS = 4'd13;
  localparam logic [3:0] C_OP_CMP  = 4'd14;

  logic             r_carry;
  logic             r_s1_valid, r_s2_valid;
  logic [WIDTH-1:0] r_s1_res,   r_s2_res;
  logic [3:0]       r_s1_flags, r_s2_flags;
  logic             r_s1_err,   r_s2_err;

  logic             w_accept, w_s2_free;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add, w_adc, w_sub, w_sbc, w_shl, w_shr;
  logic signed [WIDTH:0] w_sar_in, w_sar;
  logic             w_v_add, w_v_adc, w_v_sub, w_v_sbc;
  logic [WIDTH-1:0] w_res, w_nzv;
  logic             w_c, w_v, w_err, w_upd;
  logic [3:0]       w_flags;

  assign w_s2_free    = !r_s2_valid || bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s2_free;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Extra top bit captures carry/borrow; shifts keep the last bit out in the spare bit
  assign w_shamt  = bus.b[SHW-1:0];
  assign w_add    = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_adc    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, r_carry};
  assign w_sub    = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_sbc    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, ~r_carry};
  assign w_shl    = {1'b0, bus.a} << w_shamt;
  assign w_shr    = {bus.a, 1'b0} >> w_shamt;
  assign w_sar_in = {bus.a, 1'b0};
  assign w_sar    = w_sar_in >>> w_shamt;

  assign w_v_add = (bus.a[MSB] == bus.b[MSB]) && (w_add[MSB] != bus.a[MSB]);
  assign w_v_adc = (bus.a[MSB] == bus.b[MSB]) && (w_adc[MSB] != bus.a[MSB]);
  assign w_v_sub = (bus.a[MSB] != bus.b[MSB]) && (w_sub[MSB] != bus.a[MSB]);
  assign w_v_sbc = (bus.a[MSB] != bus.b[MSB]) && (w_sbc[MSB] != bus.a[MSB]);

  // Opcode decode: result, carry, overflow, error, and whether carry_q updates
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    w_upd = 1'b0;
    case (bus.op)
      C_OP_ADD:  begin w_res = w_add[MSB:0]; w_c = w_add[WIDTH];  w_v = w_v_add; w_upd = 1'b1; end
      C_OP_SUB:  begin w_res = w_sub[MSB:0]; w_c = ~w_sub[WIDTH]; w_v = w_v_sub; w_upd = 1'b1; end
      C_OP_NOT:  w_res = ~bus.a;
      C_OP_NAND: w_res = ~(bus.a & bus.b);
      C_OP_NOR:  w_res = ~(bus.a | bus.b);
      C_OP_AND:  w_res = bus.a & bus.b;
      C_OP_OR:   w_res = bus.a | bus.b;
      C_OP_XOR:  w_res = bus.a ^ bus.b;
      C_OP_SHL:  begin w_res = w_shl[MSB:0];   w_c = w_shl[WIDTH]; w_upd = 1'b1; end
      C_OP_SHR:  begin w_res = w_shr[WIDTH:1]; w_c = w_shr[0];     w_upd = 1'b1; end
      C_OP_SAR:  begin w_res = w_sar[WIDTH:1]; w_c = w_sar[0];     w_upd = 1'b1; end
      C_OP_ADC:  begin w_res = w_adc[MSB:0]; w_c = w_adc[WIDTH];  w_v = w_v_adc; w_upd = 1'b1; end
      C_OP_SBC:  begin w_res = w_sbc[MSB:0]; w_c = ~w_sbc[WIDTH]; w_v = w_v_sbc; w_upd = 1'b1; end
      C_OP_PASS: w_res = bus.a;
      C_OP_CMP:  begin w_res = bus.a;        w_c = ~w_sub[WIDTH]; w_v = w_v_sub; w_upd = 1'b1; end
      default:   w_err = 1'b1;
    endcase
    // CMP reports N/Z of the difference while passing A through as the result
    w_nzv   = (bus.op == C_OP_CMP) ? w_sub[MSB:0] : w_res;
    w_flags = w_err ? 4'b0000 : {w_nzv[MSB], ~|w_nzv, w_c, w_v};
  end

  // Carry register follows the C flag of each accepted carry-producing op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_accept && w_upd) begin
      r_carry <= w_c;
    end
  end

  // Stage 1: capture the computed op, drain into stage 2 when it has room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_res   <= '0;
      r_s1_flags <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_res   <= w_res;
      r_s1_flags <= w_flags;
      r_s1_err   <= w_err;
    end else if (w_s2_free) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_flags <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res   <= r_s1_res;
        r_s2_flags <= r_s1_flags;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.result    = r_s2_res;
  assign bus.flags     = r_s2_flags;
  assign bus.err       = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe: directed corner cases plus
//            random traffic scored against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [12:0] exp_q[$];   // {err, flags[3:0], result[7:0]}
  bit          m_carry = 1'b0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic logic [12:0] ref_op(input int ua, input int ub, input int op,
                                         input bit cin, output bit cout);
    int sa, sb, r, res, nzv, s, bi;
    bit c, v, upd, e;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    s  = ub % W;
    bi = 1 - int'(cin);
    r = 0; c = 0; v = 0; upd = 0; e = 0;
    case (op)
      0:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); upd = 1; end
      1, 14: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); upd = 1; end
      2:  r = 255 - ua;
      3:  r = 255 - (ua & ub);
      4:  r = 255 - (ua | ub);
      5:  r = ua & ub;
      6:  r = ua | ub;
      7:  r = ua ^ ub;
      8:  begin r = ua * (2 ** s); c = (s == 0) ? 1'b0 : 1'((ua >> (W - s)) & 1); upd = 1; end
      9:  begin r = ua / (2 ** s); c = (s == 0) ? 1'b0 : 1'((ua >> (s - 1)) & 1); upd = 1; end
      10: begin r = sa >>> s;      c = (s == 0) ? 1'b0 : 1'((ua >> (s - 1)) & 1); upd = 1; end
      11: begin r = ua + ub + int'(cin); c = (r > 255);
                v = (sa + sb + int'(cin) > 127) || (sa + sb + int'(cin) < -128); upd = 1; end
      12: begin r = ua - ub - bi; c = (ua >= ub + bi);
                v = (sa - sb - bi > 127) || (sa - sb - bi < -128); upd = 1; end
      13: r = ua;
      default: e = 1;
    endcase
    nzv  = r & 255;
    res  = (op == 14) ? ua : nzv;
    cout = upd ? c : cin;
    if (e) ref_op = {1'b1, 4'b0000, 8'h00};
    else   ref_op = {1'b0, (nzv >= 128), (nzv == 0), c, v, 8'(res)};
  endfunction

  // Scoreboard: retire handshaken results, then enqueue newly accepted ops
  always @(negedge clk) begin
    logic [12:0] e;
    bit nc;
    if (!rst_n) begin
      exp_q.delete();
      m_carry = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(bus.result), 32'(e[7:0]));
          check("sb_flags",  32'(bus.flags),  32'(e[11:8]));
          check("sb_err",    32'(bus.err),    32'(e[12]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_op(int'(bus.a), int'(bus.b), int'(bus.op), m_carry, nc);
        m_carry = nc;
        exp_q.push_back(e);
      end
    end
  end

  // Drive one request and hold it until accepted; returns at posedge+1
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.a = ia; bus.b = ib; bus.op = iop;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("issue_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] r, input logic [3:0] f, input logic e);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(r));
    check({tag, "_flags"}, 32'(bus.flags), 32'(f));
    check({tag, "_err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic one_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] iop, input logic [7:0] r, input logic [3:0] f, input logic e);
    issue(ia, ib, iop);
    wait_out();
    expect_out(tag, r, f, e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_flags",     32'(bus.flags),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

    // Exact 2-cycle latency, carry chain ADD -> ADC back to back
    issue(8'hFF, 8'h01, 4'd0);
    check("lat_s1_not_valid", 32'(bus.out_valid), 32'd0);
    issue(8'h00, 8'h00, 4'd11);
    expect_out("add_ff_01", 8'h00, 4'b0110, 1'b0);
    @(posedge clk);
    #1;
    expect_out("adc_chain", 8'h01, 4'b0000, 1'b0);
    idle(2);

    one_op("sub_80_01", 8'h80, 8'h01, 4'd1,  8'h7F, 4'b0011, 1'b0);
    one_op("cmp_05_07", 8'h05, 8'h07, 4'd14, 8'h05, 4'b1000, 1'b0);
    one_op("sar_81_1",  8'h81, 8'h01, 4'd10, 8'hC0, 4'b1010, 1'b0);
    one_op("shl_81_0",  8'h81, 8'h00, 4'd8,  8'h81, 4'b1000, 1'b0);
    one_op("illegal",   8'h12, 8'h34, 4'd15, 8'h00, 4'b0000, 1'b1);
    idle(2);

    // Backpressure: two ops fill the pipe, third is held off
    bus.out_ready = 1'b0;
    issue(8'h10, 8'h20, 4'd0);
    issue(8'hF0, 8'h0F, 4'd7);
    bus.in_valid = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.op = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      expect_out("stall_hold", 8'h30, 4'b0000, 1'b0);
    end
    bus.out_ready = 1'b1;
    issue(8'h01, 8'h02, 4'd6);
    expect_out("rel_2nd", 8'hFF, 4'b1000, 1'b0);
    @(posedge clk);
    #1;
    expect_out("rel_3rd", 8'h03, 4'b0000, 1'b0);
    idle(2);

    // Asynchronous reset with two ops in flight
    bus.out_ready = 1'b0;
    issue(8'hFF, 8'h01, 4'd0);
    issue(8'h7F, 8'h01, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_flags",     32'(bus.flags),     32'd0);
    check("arst_result",    32'(bus.result),    32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("no_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    one_op("adc_after_rst", 8'h00, 8'h00, 4'd11, 8'h00, 4'b0100, 1'b0);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.op        = 4'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);
    check("final_idle", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width; power of two, >= 4.
REQ-002 Parameter: SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  operation request valid.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shift ops.
REQ-009 Port: op  input  4  opcode.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: result  output  WIDTH  operation result.
REQ-013 Port: flags  output  4  {N,Z,C,V} for result.
REQ-014 Port: err  output  1  illegal opcode indicator, qualified by out_valid.

Function
REQ-015 Accept on clk edge when in_valid && in_ready; compute combinationally from a/b/op/carry_q and load into stage S1; S1 moves to output stage S2 when S2 empty or out_ready.
REQ-016 Latency SHALL be exactly 2 cycles without stall: accepted at edge N -> out_valid high after edge N+1, visible through edge N+2 handshake; throughput 1 op/cycle.
REQ-017 in_ready = !S1_valid || !S2_valid || out_ready; no request dropped, duplicated, or reordered.
REQ-018 result/flags/err SHALL hold stable while out_valid && !out_ready.
REQ-019 Opcodes: 0 ADD, 1 SUB (A-B), 2 NOT A, 3 NAND, 4 NOR, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR logical, 10 SAR, 11 ADC (A+B+carry_q), 12 SBC (A-B-!carry_q), 13 PASS A, 14 CMP (flags of A-B, result = A), 15 illegal.
REQ-020 Arithmetic modulo 2^WIDTH; C = carry-out for ADD/ADC; C = no-borrow (1 when no borrow) for SUB/SBC/CMP.
REQ-021 V = signed two's-complement overflow for ops 0,1,11,12,14; V = 0 otherwise.
REQ-022 Shifts: C = last bit shifted out; shift amount 0 -> result = A, C = 0; SAR replicates A[WIDTH-1].
REQ-023 Logic ops, NOT, PASS: C = 0, V = 0.
REQ-024 N = result[WIDTH-1]; Z = (result == 0); for CMP, N/Z reflect A-B, not result.
REQ-025 carry_q (internal) SHALL update to the op's C at acceptance for ops 0,1,8-12,14 only; other ops leave it unchanged; next accepted ADC/SBC uses the updated value with no hazard.
REQ-026 Op 15: result = 0, flags = 0, err = 1, carry_q unchanged; err = 0 for all other ops.

Reset
REQ-027 rst_n low SHALL immediately clear S1/S2 valid, out_valid = 0, result = 0, flags = 0, err = 0, carry_q = 0, regardless of clk.
REQ-028 in_ready SHALL be 1 while rst_n low and on the first edge after release; in-flight ops at reset are discarded with no output.

Verification
REQ-029 WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> 2 cycles later result=0x00, N=0 Z=1 C=1 V=0.
REQ-030 ADD 0xFF+0x01 then back-to-back ADC 0x00+0x00 -> second result=0x01, C=0, one result per cycle.
REQ-031 SUB 0x80-0x01 -> 0x7F, C=1, V=1; CMP 0x05,0x07 -> result=0x05, N=1, C=0, Z=0.
REQ-032 SAR 0x81 by 1 -> 0xC0, C=1; SHL 0x81 by 0 -> 0x81, C=0; op=15 -> result 0x00, err=1.
REQ-033 out_ready=0, issue 3 ops continuously -> 2 accepted, in_ready=0, outputs stable; release -> 3 results in issue order.
REQ-034 Assert rst_n=0 mid-stream with 2 ops in flight -> out_valid, flags, carry_q cleared asynchronously; no stale result after release; ADC after release uses carry 0.
